load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core byte/half/word accesses onto a 32-bit request/grant/rvalid data bus.
// Optional bus-wait timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  // core side
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  // bus side
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_err_i
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  if (ADDR_W < 3 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("load_store_unit: illegal ADDR_W or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                dreq_q, dreq_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                misaligned_c;
  logic                timeout_c;
  logic [31:0]         shifted_c;
  logic [31:0]         load_ext_c;

  assign misaligned_c = (req_size_i == 2'b11) ||
                        ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                        ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

  // Right-align the addressed lane and extend to 32 bits.
  always_comb begin
    shifted_c  = dmem_rdata_i >> {off_q, 3'b000};
    load_ext_c = shifted_c;
    case (size_q)
      SZ_BYTE: load_ext_c = uns_q ? {24'h000000, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: load_ext_c = uns_q ? {16'h0000, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_c;

  assign busy_c    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign timeout_c = busy_c && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Cycles spent in REQ plus WAIT for the current access.
  always_comb begin
    cnt_d = '0;
    if (busy_c) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (misaligned_c) begin
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
            we_d    = req_we_i;
            size_d  = req_size_i;
            uns_d   = req_unsigned_i;
            off_d   = req_addr_i[1:0];
            addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = req_wdata_i << {req_addr_i[1:0], 3'b000};
            case (req_size_i)
              SZ_BYTE: be_d = 4'(4'b0001 << req_addr_i[1:0]);
              SZ_HALF: be_d = 4'(4'b0011 << req_addr_i[1:0]);
              default: be_d = 4'b1111;
            endcase
          end
        end
      end
      S_REQ: begin
        if (timeout_c)       state_d = S_ERR;
        else if (dmem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = dmem_err_i;
          rsp_rdata_d = we_q ? 32'h0 : load_ext_c;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    dreq_d  = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      dreq_q      <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      dreq_q      <= dreq_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_err_o    = rsp_err_q;
  assign dmem_req_o   = dreq_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule
